// File: rtl/io_bus_arbiter.sv
// Two-requester read arbiter for a shared memory-mapped IO bus.
// Alternating tie-break, fixed address hold time, one-cycle bus turnaround.
module io_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter logic [63:0] IDLE_ADDRESS = 64'h0
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        REQ0,
    input  logic [63:0] ADDR0,
    input  logic        REQ1,
    input  logic [63:0] ADDR1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [63:0] RDATA,
    output logic [63:0] BUS_ADDRESS,
    input  logic [63:0] BUS_DATA,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        busy_q, busy_d;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] addr_q, addr_d;
    logic        pick0, pick1;

    // last_q==1 means requester 1 was granted last, so requester 0 wins a tie.
    always_comb begin
        pick0 = REQ0 && (!REQ1 || last_q);
        pick1 = REQ1 && (!REQ0 || !last_q);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pick0 || pick1) state_d = ST_ACCESS;
            ST_ACCESS:  if (cnt_q == 4'd0) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                addr_d = IDLE_ADDRESS;
                if (pick0) begin
                    gnt0_d = 1'b1;
                    addr_d = ADDR0;
                    cnt_d  = 4'(WAIT_CYCLES - 1);
                    last_d = 1'b0;
                end else if (pick1) begin
                    gnt1_d = 1'b1;
                    addr_d = ADDR1;
                    cnt_d  = 4'(WAIT_CYCLES - 1);
                    last_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                // Address and grant stay frozen; only the hold counter moves.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = BUS_DATA;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    addr_d  = IDLE_ADDRESS;
                end
            end
            default: begin
                addr_d = IDLE_ADDRESS;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 64'h0;
            addr_q  <= IDLE_ADDRESS;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end

    assign GNT0        = gnt0_q;
    assign GNT1        = gnt1_q;
    assign DONE0       = done0_q;
    assign DONE1       = done1_q;
    assign BUSY        = busy_q;
    assign RDATA       = rdata_q;
    assign BUS_ADDRESS = addr_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: one instance at WAIT_CYCLES=2, one at 1.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [63:0] addr0, addr1, bdata;
    logic        gnt0, gnt1, done0, done1, busy;
    logic [63:0] rdata, baddr;

    logic        b_req0;
    logic [63:0] b_addr0, b_bdata;
    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_busy;
    logic [63:0] b_rdata, b_baddr;

    int nvec = 0;
    int nmis = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.WAIT_CYCLES(2), .IDLE_ADDRESS(64'h0)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n),
        .REQ0(req0), .ADDR0(addr0), .REQ1(req1), .ADDR1(addr1),
        .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1),
        .RDATA(rdata), .BUS_ADDRESS(baddr), .BUS_DATA(bdata), .BUSY(busy)
    );

    io_bus_arbiter #(.WAIT_CYCLES(1), .IDLE_ADDRESS(64'h0)) dut1 (
        .CLOCK_50(clk), .RESET_N(rst_n),
        .REQ0(b_req0), .ADDR0(b_addr0), .REQ1(1'b0), .ADDR1(64'h0),
        .GNT0(b_gnt0), .GNT1(b_gnt1), .DONE0(b_done0), .DONE1(b_done1),
        .RDATA(b_rdata), .BUS_ADDRESS(b_baddr), .BUS_DATA(b_bdata), .BUSY(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mutual exclusion of grants and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("gnt_excl", 64'(gnt0 & gnt1), 64'h0);
            chk("done_excl", 64'(done0 & done1), 64'h0);
        end
    end

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; addr0 = 64'h0; addr1 = 64'h0; bdata = 64'h0;
        b_req0 = 1'b0; b_addr0 = 64'h0; b_bdata = 64'h0;
        repeat (2) tick();
        chk("rst_gnt0", 64'(gnt0), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_baddr", baddr, 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_done0", 64'(done0), 64'h0);
        mon_on = 1'b1;

        // Single read; address change after grant must not reach the bus.
        rst_n = 1'b1; req0 = 1'b1; addr0 = 64'h0100_0000_0000_0001; bdata = 64'hDEAD_BEEF;
        tick();
        chk("t1_gnt0", 64'(gnt0), 64'h1);
        chk("t1_baddr", baddr, 64'h0100_0000_0000_0001);
        chk("t1_busy", 64'(busy), 64'h1);
        addr0 = 64'h0100_0000_0000_0000;
        tick();
        chk("t1_gnt0_hold", 64'(gnt0), 64'h1);
        chk("t1_done0_early", 64'(done0), 64'h0);
        chk("t1_baddr_hold", baddr, 64'h0100_0000_0000_0001);
        tick();
        chk("t1_done0", 64'(done0), 64'h1);
        chk("t1_gnt0_off", 64'(gnt0), 64'h0);
        chk("t1_rdata", rdata, 64'hDEAD_BEEF);
        chk("t1_baddr_idle", baddr, 64'h0);
        tick();
        chk("t1_done0_off", 64'(done0), 64'h0);
        chk("t1_busy_off", 64'(busy), 64'h0);
        req0 = 1'b0;
        tick();
        chk("t1_no_regrant", 64'(gnt0), 64'h0);

        // Both requests held after reset: 0,1,0 with DONE pulses 4 cycles apart.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1;
        addr0 = 64'h0100_0000_0000_0000; addr1 = 64'h0200_0000_0000_0001; bdata = 64'h1111;
        tick();
        chk("t2_first_gnt0", 64'(gnt0), 64'h1);
        chk("t2_first_gnt1", 64'(gnt1), 64'h0);
        repeat (2) tick();
        chk("t2_done0", 64'(done0), 64'h1);
        chk("t2_rdata0", rdata, 64'h1111);
        bdata = 64'h2222;
        repeat (2) tick();
        chk("t2_gnt1", 64'(gnt1), 64'h1);
        chk("t2_gnt0_off", 64'(gnt0), 64'h0);
        chk("t2_baddr1", baddr, 64'h0200_0000_0000_0001);
        repeat (2) tick();
        chk("t2_done1", 64'(done1), 64'h1);
        chk("t2_done0_quiet", 64'(done0), 64'h0);
        chk("t2_rdata1", rdata, 64'h2222);
        repeat (2) tick();
        chk("t2_gnt0_again", 64'(gnt0), 64'h1);
        chk("t2_gnt1_again", 64'(gnt1), 64'h0);
        repeat (3) tick();
        req0 = 1'b0;

        // Requester 1 alone, dropping REQ1 one cycle after the grant.
        bdata = 64'h3333;
        tick();
        chk("t3_gnt1", 64'(gnt1), 64'h1);
        req1 = 1'b0;
        repeat (2) tick();
        chk("t3_done1", 64'(done1), 64'h1);
        chk("t3_rdata", rdata, 64'h3333);
        repeat (2) tick();
        chk("t3_no_gnt1", 64'(gnt1), 64'h0);
        chk("t3_no_gnt0", 64'(gnt0), 64'h0);
        chk("t3_idle", 64'(busy), 64'h0);

        // Reset pulsed mid-ACCESS: immediate clear, no DONE, re-grant after release.
        req1 = 1'b1; addr1 = 64'h0200_0000_0000_0000;
        tick();
        chk("t4_gnt1", 64'(gnt1), 64'h1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t4_async_gnt1", 64'(gnt1), 64'h0);
        chk("t4_async_busy", 64'(busy), 64'h0);
        chk("t4_async_baddr", baddr, 64'h0);
        chk("t4_async_rdata", rdata, 64'h0);
        tick();
        chk("t4_no_done1", 64'(done1), 64'h0);
        rst_n = 1'b1;
        tick();
        chk("t4_regrant1", 64'(gnt1), 64'h1);
        chk("t4_baddr", baddr, 64'h0200_0000_0000_0000);
        repeat (2) tick();
        chk("t4_done1", 64'(done1), 64'h1);
        req1 = 1'b0;
        repeat (2) tick();

        // WAIT_CYCLES=1 instance, REQ0 held: a transaction every 3 cycles.
        b_req0 = 1'b1; b_addr0 = 64'h0300_0000_0000_0001; b_bdata = 64'h5555;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_gnt0", 64'(b_gnt0), 64'h1);
            chk("t5_baddr", b_baddr, 64'h0300_0000_0000_0001);
            tick();
            chk("t5_done0", 64'(b_done0), 64'h1);
            chk("t5_gnt0_off", 64'(b_gnt0), 64'h0);
            chk("t5_rdata", b_rdata, b_bdata);
            b_bdata = b_bdata + 64'h1;
            tick();
            chk("t5_release", 64'(b_done0), 64'h0);
            chk("t5_release_gnt", 64'(b_gnt0), 64'h0);
        end
        b_req0 = 1'b0;
        mon_on = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
